// File: rtl/spm_ex_loader_pkg.sv
// Shared widths, field layout and FSM encoding for the scratchpad external-side loader.
package spm_ex_loader_pkg;
  localparam int EX_IN_W  = 168;
  localparam int EX_OUT_W = 128;
  localparam int A_W      = 8;
  localparam int D_W      = 32;
  localparam int NBG      = 4;
  localparam int LEN_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

  // Scratchpad addresses wrap modulo 256.
  function automatic logic [A_W-1:0] wrap_addr(input logic [A_W-1:0] base,
                                               input logic [A_W-1:0] idx);
    return base + idx;
  endfunction
endpackage

// File: rtl/spm_ex_loader_if.sv
// Host-side command, write-stream and read-stream signals of the loader.
interface spm_ex_loader_if;
  import spm_ex_loader_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [1:0]       cmd_bg;
  logic [A_W-1:0]   cmd_base;
  logic [LEN_W-1:0] cmd_len;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [D_W-1:0]   wdata;
  logic             rdata_valid;
  logic             rdata_ready;
  logic [D_W-1:0]   rdata;
  logic             done;

  modport master (
    output cmd_valid, cmd_dir, cmd_bg, cmd_base, cmd_len,
    output wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, done
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_bg, cmd_base, cmd_len,
    input  wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata, done
  );
endinterface

// File: rtl/spm_rd_fifo.sv
// Show-ahead synchronous FIFO holding returned read words until the host accepts them.
module spm_rd_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CW-1:0]     count_o,
  output logic              empty_o,
  output logic              full_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/spm_ex_loader.sv
// Serialises host burst commands into single-word scratchpad external-port accesses
// and streams read data back through a credit-limited return FIFO.
module spm_ex_loader
  import spm_ex_loader_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  spm_ex_loader_if.slave      bus,
  output logic [EX_IN_W-1:0]  ex_in_bus,
  input  logic [EX_OUT_W-1:0] ex_out_bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                   state_q, state_d;
  logic [1:0]               bg_q, bg_d;
  logic [A_W-1:0]           base_q, base_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]         ocnt_q, ocnt_d;
  logic [NBG-1:0]           wen_q, wen_d, ren_q, ren_d;
  logic [NBG-1:0][A_W-1:0]  addr_q, addr_d;
  logic [NBG-1:0][D_W-1:0]  data_q, data_d;
  logic                     done_q, done_d;
  logic [RD_LAT-1:0]        sr_q;

  logic [NBG-1:0][D_W-1:0]  out_lanes;
  logic                     fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [D_W-1:0]           fifo_dout;
  logic [CW-1:0]            fifo_count;
  logic [31:0]              occ;
  logic                     credit_ok;

  assign out_lanes = ex_out_bus;
  assign ex_in_bus = {wen_q, ren_q, addr_q, data_q};
  assign fifo_push = sr_q[RD_LAT-1] & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & bus.rdata_ready;

  assign bus.cmd_ready   = (state_q == ST_IDLE) & ~rst;
  assign bus.wdata_ready = (state_q == ST_WRITE);
  assign bus.rdata_valid = ~fifo_empty;
  assign bus.rdata       = fifo_dout;
  assign bus.done        = done_q;

  spm_rd_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(D_W)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (out_lanes[bg_q]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Every read on the bus or in the latency pipe already owns a FIFO slot.
  always_comb begin
    occ = 32'(fifo_count) + 32'(|ren_q);
    for (int k = 0; k < RD_LAT; k++) occ = occ + 32'(sr_q[k]);
    credit_ok = (occ < 32'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ocnt_d  = fifo_pop ? ocnt_q + LEN_W'(1) : ocnt_q;
    wen_d   = '0;
    ren_d   = '0;
    addr_d  = '0;
    data_d  = '0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          bg_d   = bus.cmd_bg;
          base_d = bus.cmd_base;
          len_d  = bus.cmd_len;
          idx_d  = '0;
          ocnt_d = '0;
          if (bus.cmd_len == '0) done_d  = 1'b1;
          else                   state_d = bus.cmd_dir ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.wdata_valid) begin
          wen_d[bg_q]  = 1'b1;
          addr_d[bg_q] = wrap_addr(base_q, idx_q[A_W-1:0]);
          data_d[bg_q] = bus.wdata;
          idx_d        = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          ren_d[bg_q]  = 1'b1;
          addr_d[bg_q] = wrap_addr(base_q, idx_q[A_W-1:0]);
          idx_d        = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && (ocnt_q == len_q - LEN_W'(1))) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bg_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ocnt_q  <= '0;
      wen_q   <= '0;
      ren_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ocnt_q  <= ocnt_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sr_q[0] <= |ren_q;
      for (int k = 1; k < RD_LAT; k++) sr_q[k] <= sr_q[k-1];
    end
  end
endmodule
